uart_tx_fifo: RTL and testbench

- Buffered UART transmitter (8N1, LSB first). It serialises bytes pushed by fabric logic onto the `tx` pin.
- Counterpart to the receive path that feeds command bytes into the top level. Fabric uses it to send status and echo bytes back to the host.
- A small FIFO absorbs bursts so the producer is not stalled for a full frame per byte.

---
 rtl/uart_tx_fifo_pkg.sv | 16 +
 rtl/uart_tx_fifo_if.sv | 23 ++
 rtl/uart_tx_fifo_sync_fifo.sv | 61 ++++++
 rtl/uart_tx_fifo.sv | 134 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART framing constants and FSM encodings for the transmit and receive paths.
package uart_tx_fifo_pkg;

  localparam int DATA_BITS            = 8;
  localparam int STOP_BITS            = 1;
  localparam int FRAME_BITS           = 1 + DATA_BITS + STOP_BITS;
  localparam int DEFAULT_CLKS_PER_BIT = 104;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Producer-side handshake and status bundle of the buffered UART transmitter.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 4
);

  logic [7:0]                    tx_byte;
  logic                          tx_valid;
  logic                          tx_ready;
  logic                          tx;
  logic                          busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output tx_byte, tx_valid,
    input  tx_ready, tx, busy, fifo_count
  );

  modport slave (
    input  tx_byte, tx_valid,
    output tx_ready, tx, busy, fifo_count
  );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Small synchronous first-word-fall-through FIFO; the head entry is readable before it is popped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // A write is refused when full even if a read frees a slot on the same edge.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a FIFO feeds an FSM that shifts bytes out LSB first on a registered tx line.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input logic            clk,
  input logic            rst,
  uart_tx_fifo_if.slave  bus
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t       state;
  tx_state_t       state_next;
  logic [BW-1:0]   baud_cnt;
  logic [BW-1:0]   baud_next;
  logic [2:0]      bit_idx;
  logic [2:0]      bit_next;
  logic [7:0]      shift_reg;
  logic [7:0]      shift_next;
  logic            tx_q;
  logic            tx_d;
  logic            pop;
  logic            baud_last;
  logic [7:0]      fifo_data;
  logic            fifo_full;
  logic            fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.tx_valid),
    .wr_data (bus.tx_byte),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .count   (bus.fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign baud_last    = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign bus.tx_ready = !fifo_full;
  assign bus.tx       = tx_q;
  assign bus.busy     = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_q      <= 1'b1;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_idx   <= bit_next;
      shift_reg <= shift_next;
      tx_q      <= tx_d;
    end
  end

  // Popping on the last stop cycle chains frames with no idle gap.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift_reg;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_data;
          baud_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + BW'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_next = '0;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            state_next = STOP;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end else begin
          baud_next = baud_cnt + BW'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_next = '0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_data;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt + BW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The line level is decided from the upcoming state so tx can be a plain flop.
  always_comb begin
    tx_d = 1'b1;
    case (state_next)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_next[bit_next];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4 and FIFO_DEPTH=4; frames are checked every cycle.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    string      name;
  } vec_t;

  vec_t vecs[12];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(string name, int actual, int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
  endtask

  task automatic apply_stimulus(logic [7:0] data);
    bus.tx_byte  = data;
    bus.tx_valid = 1'b1;
    step();
    bus.tx_valid = 1'b0;
  endtask

  // Slot 0 (start bit) is frame[9]; each slot must hold for exactly CPB cycles.
  task automatic expect_frame(vec_t v);
    for (int i = 0; i < 10 * CPB; i++) begin
      check_output($sformatf("%s slot%0d", v.name, i / CPB), int'(bus.tx), int'(v.frame[9 - i / CPB]));
      if (i == 10 * CPB - 1) check_output($sformatf("%s busy_last", v.name), int'(bus.busy), 1);
      step();
    end
  endtask

  task automatic wait_fall(string name);
    int n = 0;
    while (bus.tx !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    check_output($sformatf("%s start_seen", name), int'(bus.tx), 0);
  endtask

  initial begin
    logic low_seen;
    vecs[0]  = '{8'h01, 10'b0100000001, "b01"};
    vecs[1]  = '{8'h02, 10'b0010000001, "b02"};
    vecs[2]  = '{8'h03, 10'b0110000001, "b03"};
    vecs[3]  = '{8'h04, 10'b0001000001, "b04"};
    vecs[4]  = '{8'h05, 10'b0101000001, "b05"};
    vecs[5]  = '{8'h06, 10'b0011000001, "b06"};
    vecs[6]  = '{8'h2A, 10'b0010101001, "b2A"};
    vecs[7]  = '{8'h55, 10'b0101010101, "b55"};
    vecs[8]  = '{8'hAA, 10'b0010101011, "bAA"};
    vecs[9]  = '{8'h0F, 10'b0111100001, "b0F"};
    vecs[10] = '{8'h00, 10'b0000000001, "b00"};
    vecs[11] = '{8'hFF, 10'b0111111111, "bFF"};

    bus.tx_byte  = 8'h00;
    bus.tx_valid = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_output("reset tx", int'(bus.tx), 1);
    check_output("reset tx_ready", int'(bus.tx_ready), 1);
    check_output("reset busy", int'(bus.busy), 0);
    check_output("reset fifo_count", int'(bus.fifo_count), 0);

    // Single frames from idle: busy on the push edge, start bit one edge later.
    for (int i = 6; i < 12; i++) begin
      apply_stimulus(vecs[i].data);
      check_output($sformatf("%s busy_on_push", vecs[i].name), int'(bus.busy), 1);
      check_output($sformatf("%s count_on_push", vecs[i].name), int'(bus.fifo_count), 1);
      check_output($sformatf("%s tx_before_start", vecs[i].name), int'(bus.tx), 1);
      step();
      expect_frame(vecs[i]);
      check_output($sformatf("%s busy_after", vecs[i].name), int'(bus.busy), 0);
      check_output($sformatf("%s idle_tx", vecs[i].name), int'(bus.tx), 1);
      check_output($sformatf("%s count_after", vecs[i].name), int'(bus.fifo_count), 0);
      step();
    end

    // Burst of six with tx_valid held: FIFO fills, sixth waits for a pop, frames abut.
    fork
      begin
        for (int b = 1; b <= 6; b++) begin
          int g = 0;
          bus.tx_byte  = 8'(b);
          bus.tx_valid = 1'b1;
          while (!bus.tx_ready && g < 400) begin
            step();
            g++;
          end
          check_output($sformatf("burst ready_for_%0d", b), int'(bus.tx_ready), 1);
          step();
          if (b == 5) begin
            check_output("burst full_ready", int'(bus.tx_ready), 0);
            check_output("burst full_count", int'(bus.fifo_count), 4);
          end
        end
        bus.tx_valid = 1'b0;
      end
      begin
        wait_fall("burst");
        for (int k = 0; k < 6; k++) expect_frame(vecs[k]);
        check_output("burst busy_end", int'(bus.busy), 0);
        check_output("burst tx_end", int'(bus.tx), 1);
      end
    join
    step();

    // Push 0xAA on the very edge that pops the queued byte at the end of 0x55's stop bit.
    bus.tx_byte  = 8'h55;
    bus.tx_valid = 1'b1;
    step();
    bus.tx_byte  = 8'h0F;
    step();
    bus.tx_valid = 1'b0;
    check_output("pushpop count_before", int'(bus.fifo_count), 1);
    fork
      expect_frame(vecs[7]);
      begin
        repeat (10 * CPB - 1) step();
        bus.tx_byte  = 8'hAA;
        bus.tx_valid = 1'b1;
        step();
        bus.tx_valid = 1'b0;
        check_output("pushpop count_same", int'(bus.fifo_count), 1);
      end
    join
    expect_frame(vecs[9]);
    expect_frame(vecs[8]);
    check_output("pushpop busy_end", int'(bus.busy), 0);
    step();

    // Reset in the middle of 0x0F's data bit 3 with two bytes still queued.
    bus.tx_byte  = 8'h0F;
    bus.tx_valid = 1'b1;
    step();
    bus.tx_byte  = 8'h01;
    step();
    bus.tx_byte  = 8'h02;
    step();
    bus.tx_valid = 1'b0;
    check_output("midreset queued", int'(bus.fifo_count), 2);
    repeat (15) step();
    check_output("midreset bit3", int'(bus.tx), 1);
    check_output("midreset busy_before", int'(bus.busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_output("midreset tx", int'(bus.tx), 1);
    check_output("midreset count", int'(bus.fifo_count), 0);
    check_output("midreset busy", int'(bus.busy), 0);
    check_output("midreset ready", int'(bus.tx_ready), 1);
    low_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) low_seen = 1'b1;
      step();
    end
    check_output("midreset no_more_frames", int'(low_seen), 0);

    // 0x00 then 0xFF back to back: long low run, then long high run.
    bus.tx_byte  = 8'h00;
    bus.tx_valid = 1'b1;
    step();
    bus.tx_byte  = 8'hFF;
    step();
    bus.tx_valid = 1'b0;
    expect_frame(vecs[10]);
    expect_frame(vecs[11]);
    check_output("extremes busy_end", int'(bus.busy), 0);

    // tx_valid while reset is held must never enqueue anything.
    rst          = 1'b1;
    bus.tx_byte  = 8'h5A;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_output($sformatf("rsthold count%0d", i), int'(bus.fifo_count), 0);
    end
    bus.tx_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    check_output("rsthold count_after", int'(bus.fifo_count), 0);
    check_output("rsthold busy_after", int'(bus.busy), 0);
    step();
    check_output("rsthold tx_after", int'(bus.tx), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
